// File: rtl/fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_stream_reader                                           |
// | Description : Read-side master for the circular fifo. Issues pops, absorbs |
// |               the fifo's 1-cycle read latency into a 2-entry skid buffer   |
// |               and re-presents the words as a valid/ready stream.           |
// | Option      : FIFO_READER_CNT_EN adds beat_cnt_o (delivered-word counter). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_stream_reader #(
  parameter int XLEN  = 32
`ifdef FIFO_READER_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_en_i,
  input  logic              fifo_empty_i,
  input  logic [XLEN-1:0]   fifo_data_i,
  output logic              fifo_pop_en_o,
  output logic              m_valid_o,
  output logic [XLEN-1:0]   m_data_o,
`ifdef FIFO_READER_CNT_EN
  output logic [CNT_W-1:0]  beat_cnt_o,
`endif
  input  logic              m_ready_i
);

  localparam logic [1:0] C_DEPTH = 2'd2;

  logic [XLEN-1:0] skid_q [2];
  logic            rd_q;
  logic            rd_d;
  logic [1:0]      cnt_q;
  logic [1:0]      cnt_d;
  logic            inflight_q;

  logic            w_fire;
  logic [1:0]      w_occ;
  logic            w_wr_idx;

  // Output view: head of the skid buffer, never bypassed from the fifo bus.
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = skid_q[rd_q];
  assign w_fire    = m_valid_o & m_ready_i;

  // Credits in use: buffered words plus the word already requested.
  assign w_occ    = cnt_q + {1'b0, inflight_q};
  // Landing slot for the in-flight word, wrapping over the two entries.
  assign w_wr_idx = rd_q ^ cnt_q[0];

  // Pop only when a slot is guaranteed free by the time the word arrives.
  assign fifo_pop_en_o = !fifo_empty_i && !flush_en_i && !rst_i &&
                         ((w_occ < C_DEPTH) || ((w_occ == C_DEPTH) && w_fire));

  // Next-state for occupancy and head pointer from capture/fire events.
  always_comb begin
    cnt_d = cnt_q;
    rd_d  = rd_q;
    unique case ({inflight_q, w_fire})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (w_fire) begin
      rd_d = ~rd_q;
    end
  end

  // Buffer state; flush drops buffered and in-flight words, reset also clears data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= 2'd0;
      rd_q       <= 1'b0;
      inflight_q <= 1'b0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
    end else if (flush_en_i) begin
      cnt_q      <= 2'd0;
      rd_q       <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      inflight_q <= fifo_pop_en_o;
      if (inflight_q) begin
        skid_q[w_wr_idx] <= fifo_data_i;
      end
    end
  end

`ifdef FIFO_READER_CNT_EN
  logic [CNT_W-1:0] beat_cnt_q;

  // Delivered-word counter; survives flush, wraps naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
    end else if (w_fire) begin
      beat_cnt_q <= beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign beat_cnt_o = beat_cnt_q;
`endif

  // The credit rule must keep the buffer within its two entries.
  a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= C_DEPTH);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inflight_q && (cnt_q == C_DEPTH) && !w_fire));

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_stream_reader                                        |
// | Description : Directed self-checking bench; includes a 4-deep fifo model   |
// |               with a registered read port feeding the reader.              |
// | Option      : FIFO_READER_CNT_EN enables the beat counter scenario.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fifo_stream_reader;
  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_en_i = 1'b0;
  logic            fifo_empty_i;
  logic [XLEN-1:0] fifo_data_i = '0;
  logic            fifo_pop_en_o;
  logic            m_valid_o;
  logic [XLEN-1:0] m_data_o;
  logic            m_ready_i = 1'b0;
`ifdef FIFO_READER_CNT_EN
  logic [31:0]     beat_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  fifo_stream_reader #(.XLEN(XLEN)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_en_i    (flush_en_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_data_i   (fifo_data_i),
    .fifo_pop_en_o (fifo_pop_en_o),
    .m_valid_o     (m_valid_o),
    .m_data_o      (m_data_o),
`ifdef FIFO_READER_CNT_EN
    .beat_cnt_o    (beat_cnt_o),
`endif
    .m_ready_i     (m_ready_i)
  );

  // ---------------- fifo model (depth 4, registered read data) ----------------
  logic [31:0] mem [4];
  logic [1:0]  wp = 2'd0;
  logic [1:0]  rp = 2'd0;
  int unsigned fcount = 0;
  logic        push_acc = 1'b0;
  logic [31:0] push_data = '0;

  assign fifo_empty_i = (fcount == 0);

  always @(posedge clk_i) begin
    if (rst_i || flush_en_i) begin
      wp     <= 2'd0;
      rp     <= 2'd0;
      fcount <= 0;
    end else begin
      if (fifo_pop_en_o && fcount != 0) begin
        fifo_data_i <= mem[rp];
        rp          <= rp + 2'd1;
      end
      if (push_acc) begin
        mem[wp] <= push_data;
        wp      <= wp + 2'd1;
      end
      fcount <= fcount + (push_acc ? 1 : 0) - ((fifo_pop_en_o && fcount != 0) ? 1 : 0);
    end
  end

  // ---------------- checking ----------------
  int          n_pass = 0;
  int          n_chk  = 0;
  int          delivered = 0;
  logic [31:0] exp_q [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        s_valid;
  logic        s_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %08h, expected %08h", tag, obs, exp);
  endtask

  // One clock: drive inputs, sample just before the edge, then advance.
  task automatic step(input logic rdy, input logic psh, input logic [31:0] pd,
                      input logic fl, input logic rs);
    m_ready_i  = rdy;
    flush_en_i = fl;
    rst_i      = rs;
    push_data  = pd;
    push_acc   = psh && (fcount < 4) && !fl && !rs;
    #3;
    s_valid = m_valid_o;
    s_pop   = fifo_pop_en_o;
    if (prev_stall) begin
      check("stall_valid", {31'b0, m_valid_o}, 32'd1);
      check("stall_data", m_data_o, prev_data);
    end
    if (fifo_pop_en_o) check("no_overpop", {31'b0, fifo_empty_i}, 32'd0);
    if (m_valid_o === 1'b1 && m_ready_i) begin
      if (exp_q.size() == 0) check("spurious_beat", {31'b0, m_valid_o}, 32'd0);
      else                   check("beat_data", m_data_o, exp_q.pop_front());
      delivered++;
    end
    prev_stall = (m_valid_o === 1'b1) && !m_ready_i && !fl && !rs;
    prev_data  = m_data_o;
    if (fl || rs) exp_q.delete();
    if (push_acc) exp_q.push_back(pd);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bit exp_v [7];
    bit exp_p [7];
    logic [31:0] w1 [3];
    int d0;
    int pushed;

    // ---------- reset ----------
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("rst_valid", {31'b0, m_valid_o}, 32'd0);
    check("rst_data", m_data_o, 32'd0);
    check("rst_pop", {31'b0, fifo_pop_en_o}, 32'd0);
`ifdef FIFO_READER_CNT_EN
    check("rst_beat", beat_cnt_o, 32'd0);
`endif

    // ---------- 1: three words, consumer ready ----------
    exp_v = '{0, 0, 0, 1, 1, 1, 0};
    exp_p = '{0, 1, 1, 1, 0, 0, 0};
    w1    = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678};
    d0 = delivered;
    for (int i = 0; i < 7; i++) begin
      step(1, i < 3, (i < 3) ? w1[i] : 32'd0, 0, 0);
      check("t1_valid", {31'b0, s_valid}, {31'b0, exp_v[i]});
      check("t1_pop", {31'b0, s_pop}, {31'b0, exp_p[i]});
    end
    check("t1_beats", delivered - d0, 32'd3);

    // ---------- 2: backpressure then burst ----------
    d0 = delivered;
    for (int i = 0; i < 4; i++) step(0, 1, 32'hA0000000 + i, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    check("t2_fifo_level", fcount, 32'd2);
    check("t2_pop_stopped", {31'b0, s_pop}, 32'd0);
    check("t2_head", m_data_o, 32'hA0000000);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      check("t2_b2b_valid", {31'b0, s_valid}, 32'd1);
    end
    step(1, 0, 0, 0, 0);
    check("t2_drained", {31'b0, s_valid}, 32'd0);
    check("t2_beats", delivered - d0, 32'd4);

    // ---------- 3: toggling ready ----------
    d0 = delivered;
    pushed = 0;
    for (int i = 0; i < 80 && (delivered - d0) < 8; i++) begin
      logic psh;
      psh = (pushed < 8) && (fcount < 4);
      step(i[0] == 1'b0, psh, 32'hB0000000 + pushed, 0, 0);
      if (psh) pushed++;
    end
    check("t3_beats", delivered - d0, 32'd8);
    check("t3_leftover", exp_q.size(), 32'd0);

    // ---------- 4: flush with a pop in flight ----------
    step(0, 0, 0, 0, 0);
    d0 = delivered;
    step(0, 1, 32'h11111111, 0, 0);
    step(0, 1, 32'h22222222, 0, 0);
    step(0, 1, 32'h33333333, 0, 0);
    check("t4_pop_issued", {31'b0, s_pop}, 32'd1);
    step(0, 0, 0, 1, 0);
    check("t4_valid_after_flush", {31'b0, m_valid_o}, 32'd0);
    step(1, 1, 32'h44444444, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    check("t4_beats", delivered - d0, 32'd1);

    // ---------- 5: reset mid-stream ----------
    for (int i = 0; i < 3; i++) step(0, 1, 32'h5A5A0001 + i, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    check("t5_buffered", {31'b0, m_valid_o}, 32'd1);
    step(1, 0, 0, 0, 1);
    check("t5_pop_in_rst", {31'b0, s_pop}, 32'd0);
    check("t5_rst_valid", {31'b0, m_valid_o}, 32'd0);
    check("t5_rst_data", m_data_o, 32'd0);
    check("t5_rst_pop", {31'b0, fifo_pop_en_o}, 32'd0);
    d0 = delivered;
    step(1, 1, 32'h5A5A0004, 0, 0);
    step(1, 1, 32'h5A5A0005, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    check("t5_beats", delivered - d0, 32'd2);

`ifdef FIFO_READER_CNT_EN
    // ---------- 6: beat counter ----------
    step(0, 0, 0, 0, 1);
    check("t6_beat_rst", beat_cnt_o, 32'd0);
    d0 = delivered;
    for (int i = 0; i < 5; i++) step(1, 1, 32'hC0000000 + i, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) step(1, 1, 32'hC1000000 + i, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    check("t6_beats", delivered - d0, 32'd7);
    check("t6_beat_cnt", beat_cnt_o, 32'd7);
    step(0, 0, 0, 0, 1);
    check("t6_beat_cleared", beat_cnt_o, 32'd0);
    step(0, 0, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
